id_ex_stage: RTL

//  ID/EX pipeline register with load-use hazard detection. Sits directly downstream of control_id.
//  - Captures control_id fields (ex/mem/wb), register-file operands, immediate, pc+4 and register numbers once per clock.
//  - Detects a load-use hazard and inserts a one-cycle bubble.
//  - Drives out_stall back to the PC and IF/ID registers.

---
 rtl/id_ex_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Registers the control_id fields, operands, immediate, pc+4 and register
// numbers once per clock. When the instruction in EX is a load and the ID
// instruction reads its destination, a one-cycle bubble is inserted and
// out_stall freezes the PC and IF/ID registers.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module id_ex_stage #(
  parameter int NB_data      = 32,
  parameter int NB_addr      = 5,
  parameter int NB_ex        = 8,
  parameter int NB_mem       = 9,
  parameter int NB_wb        = 2,
  parameter int MEM_READ_BIT = 0
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [NB_ex-1:0]   in_ex,
  input  logic [NB_mem-1:0]  in_mem,
  input  logic [NB_wb-1:0]   in_wb,
  input  logic [NB_data-1:0] in_pc_next,
  input  logic [NB_data-1:0] in_rs_data,
  input  logic [NB_data-1:0] in_rt_data,
  input  logic [NB_data-1:0] in_imm_ext,
  input  logic [NB_addr-1:0] in_rs,
  input  logic [NB_addr-1:0] in_rt,
  input  logic [NB_addr-1:0] in_rd,
  input  logic               in_valid,
  input  logic               in_flush,
  input  logic               in_hold,
  output logic [NB_ex-1:0]   out_ex,
  output logic [NB_mem-1:0]  out_mem,
  output logic [NB_wb-1:0]   out_wb,
  output logic [NB_data-1:0] out_pc_next,
  output logic [NB_data-1:0] out_rs_data,
  output logic [NB_data-1:0] out_rt_data,
  output logic [NB_data-1:0] out_imm_ext,
  output logic [NB_addr-1:0] out_rs,
  output logic [NB_addr-1:0] out_rt,
  output logic [NB_addr-1:0] out_rd,
  output logic               out_valid,
  output logic               out_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [NB_data-1:0] out_stall_cnt,
  output logic [NB_data-1:0] out_flush_cnt
`endif
);

  logic hz;
  logic bubble;

  // A load in EX whose destination (never $0) is read by the ID instruction.
  assign hz = out_valid & out_mem[MEM_READ_BIT] & (out_rt != '0) & in_valid &
              ((out_rt == in_rs) | (out_rt == in_rt));

  // A squashed instruction never needs to wait for its operands.
  assign out_stall = hz & ~in_flush;

  assign bubble = in_flush | hz;

  // Pipeline register: hold keeps everything, a bubble zeroes only control.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_ex      <= '0;
      out_mem     <= '0;
      out_wb      <= '0;
      out_pc_next <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm_ext <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_valid   <= 1'b0;
    end else if (!in_hold) begin
      out_pc_next <= in_pc_next;
      out_rs_data <= in_rs_data;
      out_rt_data <= in_rt_data;
      out_imm_ext <= in_imm_ext;
      out_rs      <= in_rs;
      out_rt      <= in_rt;
      out_rd      <= in_rd;
      if (bubble || !in_valid) begin
        out_ex    <= '0;
        out_mem   <= '0;
        out_wb    <= '0;
        out_valid <= 1'b0;
      end else begin
        out_ex    <= in_ex;
        out_mem   <= in_mem;
        out_wb    <= in_wb;
        out_valid <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; frozen together with the pipeline on hold.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_stall_cnt <= '0;
      out_flush_cnt <= '0;
    end else if (!in_hold) begin
      if (out_stall && (out_stall_cnt != '1)) out_stall_cnt <= out_stall_cnt + 1'b1;
      if (in_flush && (out_flush_cnt != '1)) out_flush_cnt <= out_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
